// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers the pixel stream and measures the timing of a VGA-style
// sync/blank/RGB input, and detects when that timing is stable.
//
// Ports
//   clk, rst_n             pixel clock; asynchronous active-low reset
//   vga_hs, vga_vs         active-low horizontal / vertical sync
//   vga_blanck_n           display enable, high = active pixel
//   vga_rgb[23:0]          pixel data
//   pix_valid/x/y/rgb      recovered pixel stream, 2 cycles after the input sample
//   h_total, v_total       clocks per line, lines per frame
//   h_active, v_active     active pixels per line, active lines per frame
//   locked                 timing stable (SEARCH -> MEASURE -> CHECK -> LOCKED)
//   frame_start            one-cycle pulse per vertical sync falling edge
//
// Optional build macro VGA_RX_CRC_EN adds frame_crc[15:0] and crc_valid:
// CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over every valid pixel of a frame.

module vga_timing_rx #(
    parameter int unsigned CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vga_hs,
    input  logic                 vga_vs,
    input  logic                 vga_blanck_n,
    input  logic [23:0]          vga_rgb,
    output logic                 pix_valid,
    output logic [CNT_WIDTH-1:0] pix_x,
    output logic [CNT_WIDTH-1:0] pix_y,
    output logic [23:0]          pix_rgb,
    output logic [CNT_WIDTH-1:0] h_total,
    output logic [CNT_WIDTH-1:0] v_total,
    output logic [CNT_WIDTH-1:0] h_active,
    output logic [CNT_WIDTH-1:0] v_active,
    output logic                 locked,
`ifdef VGA_RX_CRC_EN
    output logic [15:0]          frame_crc,
    output logic                 crc_valid,
`endif
    output logic                 frame_start
);

    typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} state_e;

    // Registered input copies plus one more delay for edge detection.
    logic        hs_q, vs_q, de_q, hs_prev_q, vs_prev_q;
    logic [23:0] rgb_q;

    logic [CNT_WIDTH-1:0] h_cnt_q, x_cnt_q, y_cnt_q, v_cnt_q;
    logic                 line_act_q;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] h_ref_q, v_ref_q;
    logic                 mismatch_q, first_line_q;

    logic                 line_start, fs_c, h_sat, line_bad, mis_cur, line_act_cur;
    logic [CNT_WIDTH-1:0] x_cur, y_line, y_cur, v_after, h_meas, v_act_meas;

    always_comb begin
        line_start   = hs_prev_q & ~hs_q;
        fs_c         = vs_prev_q & ~vs_q;
        h_sat        = &h_cnt_q;
        h_meas       = h_cnt_q + CNT_WIDTH'(1);
        // Line start is handled before frame start when both happen together.
        v_after      = v_cnt_q + CNT_WIDTH'(line_start);
        x_cur        = line_start ? '0 : x_cnt_q;
        y_line       = y_cnt_q + CNT_WIDTH'(line_start & line_act_q);
        y_cur        = fs_c ? '0 : y_line;
        line_act_cur = line_start ? 1'b0 : line_act_q;
        // A frame start in mid-line still counts the current line if it was active.
        v_act_meas   = y_line + CNT_WIDTH'(line_act_cur);
        line_bad     = line_start & ~first_line_q & (h_meas != h_ref_q);
        mis_cur      = mismatch_q | line_bad;
    end

    // Input registers, counters, measurements and pixel stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            h_cnt_q     <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_act_q  <= 1'b0;
            h_total     <= '0;
            v_total     <= '0;
            h_active    <= '0;
            v_active    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_q      <= vga_hs;
            vs_q      <= vga_vs;
            de_q      <= vga_blanck_n;
            rgb_q     <= vga_rgb;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;

            if (line_start) begin
                h_cnt_q <= '0;
            end else if (!h_sat) begin
                h_cnt_q <= h_cnt_q + CNT_WIDTH'(1);
            end

            x_cnt_q    <= x_cur + CNT_WIDTH'(de_q);
            y_cnt_q    <= y_cur;
            line_act_q <= line_act_cur | de_q;
            v_cnt_q    <= fs_c ? '0 : v_after;

            if (line_start) begin
                h_total <= h_meas;
                // Blank lines would report zero; keep the last real active width.
                if (x_cnt_q != '0) begin
                    h_active <= x_cnt_q;
                end
            end
            if (fs_c) begin
                v_total  <= v_after;
                v_active <= v_act_meas;
            end

            pix_valid   <= de_q;
            pix_rgb     <= rgb_q;
            pix_x       <= x_cur;
            pix_y       <= y_cur;
            frame_start <= fs_c;
        end
    end

    // Lock FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSearch;
            h_ref_q      <= '0;
            v_ref_q      <= '0;
            mismatch_q   <= 1'b0;
            first_line_q <= 1'b0;
            locked       <= 1'b0;
        end else if (h_sat) begin
            // No line start for a full counter range: sync is lost.
            state_q      <= StSearch;
            mismatch_q   <= 1'b0;
            first_line_q <= 1'b0;
            locked       <= 1'b0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (fs_c) begin
                        state_q      <= StMeasure;
                        mismatch_q   <= 1'b0;
                        first_line_q <= 1'b1;
                    end
                end
                StMeasure: begin
                    if (line_start && first_line_q) begin
                        h_ref_q      <= h_meas;
                        first_line_q <= 1'b0;
                    end
                    mismatch_q <= fs_c ? 1'b0 : mis_cur;
                    if (fs_c) begin
                        v_ref_q <= v_after;
                        if (!mis_cur) begin
                            state_q <= StCheck;
                        end else begin
                            first_line_q <= 1'b1;
                        end
                    end
                end
                StCheck: begin
                    mismatch_q <= fs_c ? 1'b0 : mis_cur;
                    if (fs_c) begin
                        if (!mis_cur && (v_after == v_ref_q)) begin
                            state_q <= StLocked;
                            locked  <= 1'b1;
                        end else begin
                            state_q      <= StMeasure;
                            first_line_q <= 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (line_bad || (fs_c && (v_after != v_ref_q))) begin
                        state_q    <= StSearch;
                        mismatch_q <= 1'b0;
                        locked     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StSearch;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc16_px(input logic [15:0] crc_in, input logic [23:0] px);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ px[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_q, crc_base, crc_nxt;
    logic        stay_locked;

    always_comb begin
        // The pixel in the frame-start cycle belongs to the new frame.
        crc_base    = fs_c ? 16'hFFFF : crc_q;
        crc_nxt     = de_q ? crc16_px(crc_base, rgb_q) : crc_base;
        stay_locked = (state_q == StLocked) && !h_sat && !line_bad && (v_after == v_ref_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_q     <= crc_nxt;
            crc_valid <= fs_c & stay_locked;
            if (fs_c) begin
                frame_crc <= crc_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a reduced video mode to keep runs short:
// 20 clocks/line (sync 3, back porch 3, active 12, front porch 2) and
// 12 lines/frame (sync 2, back porch 1, active 8, front porch 1).

module tb_vga_timing_rx;

    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_hs, vga_vs, vga_blanck_n;
    logic [23:0]   vga_rgb;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y, h_total, v_total, h_active, v_active;
    logic [23:0]   pix_rgb;
    logic          locked, frame_start;
`ifdef VGA_RX_CRC_EN
    logic [15:0]   frame_crc;
    logic          crc_valid;
`endif

    int total = 0;
    int bad   = 0;

    int hpos, vpos, line_len;
    bit hold, rgb_const;

    vga_timing_rx #(.CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_blanck_n (vga_blanck_n),
        .vga_rgb      (vga_rgb),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_rgb      (pix_rgb),
        .h_total      (h_total),
        .v_total      (v_total),
        .h_active     (h_active),
        .v_active     (v_active),
        .locked       (locked),
`ifdef VGA_RX_CRC_EN
        .frame_crc    (frame_crc),
        .crc_valid    (crc_valid),
`endif
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    // Drive the input for the current position, clock it in, then advance.
    task automatic step();
        vga_hs       = hold ? 1'b1 : (hpos >= 3);
        vga_vs       = hold ? 1'b1 : (vpos >= 2);
        vga_blanck_n = !hold && vpos >= 3 && vpos <= 10 && hpos >= 6 && hpos <= 17;
        vga_rgb      = rgb_const ? 24'h00FFFF : {8'(vpos), 8'(hpos), 8'h5A};
        @(posedge clk);
        #1;
        if (!hold) begin
            hpos++;
            if (hpos >= line_len) begin
                hpos     = 0;
                line_len = 20;
                vpos     = (vpos == 11) ? 0 : vpos + 1;
            end
        end
    endtask

    task automatic run_to(input int v, input int h);
        for (int i = 0; i < 1000; i++) begin
            if (vpos == v && hpos == h) break;
            step();
        end
    endtask

    task automatic wait_fs(output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Three frame starts: locked must be low at the first two pulses and high at the third.
    task automatic relock(input string tag);
        bit found;
        for (int n = 1; n <= 3; n++) begin
            wait_fs(found);
            total++;
            if (!found) begin
                bad++;
                $display("FAIL %s fs%0d timeout: frame_start never seen, required a pulse", tag, n);
            end
            total++;
            if (locked !== (n == 3)) begin
                bad++;
                $display("FAIL %s locked@fs%0d: got %b required %b", tag, n, locked, (n == 3));
            end
`ifdef VGA_RX_CRC_EN
            total++;
            if (crc_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s crc_valid@fs%0d: got %b required 0", tag, n, crc_valid);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        hold      = 1'b0;
        rgb_const = 1'b0;
        hpos      = 10;
        vpos      = 5;
        line_len  = 20;
        step();
        step();
        step();
        total++;
        if (locked !== 1'b0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: locked=%b frame_start=%b required 0/0", locked, frame_start);
        end
        total++;
        if (h_total !== '0 || v_total !== '0 || h_active !== '0 || v_active !== '0) begin
            bad++;
            $display("FAIL reset_meas: %0d %0d %0d %0d required 0 0 0 0",
                     h_total, v_total, h_active, v_active);
        end
        total++;
        if (pix_valid !== 1'b0 || pix_x !== '0 || pix_y !== '0 || pix_rgb !== '0) begin
            bad++;
            $display("FAIL reset_pix: valid=%b x=%0d y=%0d rgb=%h required all 0",
                     pix_valid, pix_x, pix_y, pix_rgb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        relock("lock");
        total++;
        if (h_total !== 11'd20) begin
            bad++;
            $display("FAIL h_total: got %0d required 20", h_total);
        end
        total++;
        if (v_total !== 11'd12) begin
            bad++;
            $display("FAIL v_total: got %0d required 12", v_total);
        end
        total++;
        if (h_active !== 11'd12) begin
            bad++;
            $display("FAIL h_active: got %0d required 12", h_active);
        end
        total++;
        if (v_active !== 11'd8) begin
            bad++;
            $display("FAIL v_active: got %0d required 8", v_active);
        end
    endtask

    task automatic test_pixels();
        run_to(3, 5);
        step();
        step();
        total++;
        if (pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL pix_before_first: valid got %b required 0", pix_valid);
        end
        step();
        total++;
        if (pix_valid !== 1'b1 || pix_x !== 11'd0 || pix_y !== 11'd0 ||
            pix_rgb !== 24'h03065A) begin
            bad++;
            $display("FAIL pix_first: valid=%b x=%0d y=%0d rgb=%h required 1 0 0 03065a",
                     pix_valid, pix_x, pix_y, pix_rgb);
        end
        run_to(6, 10);
        step();
        step();
        total++;
        if (pix_valid !== 1'b1 || pix_x !== 11'd4 || pix_y !== 11'd3 ||
            pix_rgb !== 24'h060A5A) begin
            bad++;
            $display("FAIL pix_mid: valid=%b x=%0d y=%0d rgb=%h required 1 4 3 060a5a",
                     pix_valid, pix_x, pix_y, pix_rgb);
        end
        run_to(10, 17);
        step();
        step();
        total++;
        if (pix_valid !== 1'b1 || pix_x !== 11'd11 || pix_y !== 11'd7) begin
            bad++;
            $display("FAIL pix_last: valid=%b x=%0d y=%0d required 1 11 7",
                     pix_valid, pix_x, pix_y);
        end
        step();
        total++;
        if (pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL pix_after_last: valid got %b required 0", pix_valid);
        end
    endtask

    task automatic test_short_line();
        run_to(5, 0);
        line_len = 19;
        run_to(6, 0);
        step();
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL short_before: locked got %b required 1", locked);
        end
        step();
        total++;
        if (locked !== 1'b0 || h_total !== 11'd19) begin
            bad++;
            $display("FAIL short_unlock: locked=%b h_total=%0d required 0 19", locked, h_total);
        end
        relock("short");
    endtask

    task automatic test_sync_loss();
        int fs_seen;
        fs_seen = 0;
        run_to(5, 0);
        hold = 1'b1;
        for (int i = 0; i < 1900; i++) begin
            step();
            if (frame_start === 1'b1) fs_seen++;
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL hold_early: locked got %b required 1", locked);
        end
        for (int i = 0; i < 200; i++) begin
            step();
            if (frame_start === 1'b1) fs_seen++;
        end
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL hold_lost: locked got %b required 0", locked);
        end
        total++;
        if (fs_seen != 0) begin
            bad++;
            $display("FAIL hold_fs: frame_start pulses got %0d required 0", fs_seen);
        end
        hold = 1'b0;
        relock("hold");
    endtask

    task automatic test_reset_mid();
        run_to(6, 8);
        total++;
        if (locked !== 1'b1 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: locked=%b valid=%b required 1 1", locked, pix_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || pix_valid !== 1'b0 || pix_x !== '0 || pix_y !== '0 ||
            pix_rgb !== '0) begin
            bad++;
            $display("FAIL midrst_pix: locked=%b valid=%b x=%0d y=%0d rgb=%h required all 0",
                     locked, pix_valid, pix_x, pix_y, pix_rgb);
        end
        total++;
        if (h_total !== '0 || v_total !== '0 || h_active !== '0 || v_active !== '0) begin
            bad++;
            $display("FAIL midrst_meas: %0d %0d %0d %0d required 0 0 0 0",
                     h_total, v_total, h_active, v_active);
        end
        step();
        step();
        rst_n = 1'b1;
        relock("midrst");
        total++;
        if (h_total !== 11'd20 || v_total !== 11'd12) begin
            bad++;
            $display("FAIL midrst_meas_after: h=%0d v=%0d required 20 12", h_total, v_total);
        end
    endtask

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] ref_crc(input logic [23:0] px, input int count);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int n = 0; n < count; n++) begin
            for (int b = 23; b >= 0; b--) begin
                fb = c[15] ^ px[b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic test_crc();
        bit          found;
        logic [15:0] expect_crc;
        expect_crc = ref_crc(24'h00FFFF, 96);
        rgb_const  = 1'b1;
        wait_fs(found);
        for (int n = 0; n < 2; n++) begin
            wait_fs(found);
            total++;
            if (!found || crc_valid !== 1'b1 || frame_crc !== expect_crc) begin
                bad++;
                $display("FAIL crc_frame%0d: seen=%b valid=%b crc=%h required 1 1 %h",
                         n, found, crc_valid, frame_crc, expect_crc);
            end
        end
        rgb_const = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_sync_loss();
        test_reset_mid();
`ifdef VGA_RX_CRC_EN
        test_crc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
